sdram_port_arbiter: RTL and testbench

Parametrised multi-port front end for the SDRAM controller. It replaces the fixed single-requester port manager inside the MMU. It accepts word requests from `NUM_PORTS` clients (m9k fill, DMA and tensor-worker ports), arbitrates round-robin, and splits each `PORT_DW`-bit access into `PORT_DW/SDRAM_DW` sequential SDRAM beats over the existing as/rw/done SDRAM handshake. Read beats are reassembled into a full-width word before it is returned to the granted client.

---
 rtl/sdram_port_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - round-robin multi-port front end that splits client words into SDRAM beats
module sdram_port_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int SDRAM_DW   = 16,
  parameter int SDRAM_AW   = 23,
  parameter int PORT_DW    = 32,
  localparam int BEATS     = PORT_DW / SDRAM_DW,
  localparam int LOG_BEATS = $clog2(BEATS),
  localparam int PORT_AW   = SDRAM_AW - LOG_BEATS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           port_req,
  input  logic [NUM_PORTS-1:0]           port_rw,
  input  logic [NUM_PORTS*PORT_AW-1:0]   port_addr,
  input  logic [NUM_PORTS*PORT_DW-1:0]   port_wdata,
  output logic [PORT_DW-1:0]             port_rdata,
  output logic [NUM_PORTS-1:0]           port_done,
  output logic [NUM_PORTS-1:0]           grant,
  output logic                           busy,
  input  logic                           sdram_ready,
  output logic                           sdram_as,
  output logic                           sdram_rw,
  output logic [SDRAM_AW-1:0]            sdram_addr,
  output logic [SDRAM_DW-1:0]            sdram_data_write,
  input  logic [SDRAM_DW-1:0]            sdram_data_read,
  input  logic                           sdram_done
);

  localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int BEAT_W = (LOG_BEATS > 0) ? LOG_BEATS : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       last_grant_q, last_grant_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [PORT_AW-1:0]     addr_q, addr_d;
  logic [PORT_DW-1:0]     wdata_q, wdata_d;
  logic [NUM_PORTS-1:0]   grant_q, grant_d;
  logic                   busy_q, busy_d;
  logic [NUM_PORTS-1:0]   port_done_q, port_done_d;
  logic                   sdram_rw_q, sdram_rw_d;
  logic [SDRAM_AW-1:0]    sdram_addr_q, sdram_addr_d;
  logic [SDRAM_DW-1:0]    sdram_data_write_q, sdram_data_write_d;
  logic [PORT_DW-1:0]     port_rdata_q, port_rdata_d;

  logic                   pick_found;
  logic [IDX_W-1:0]       pick_idx;
  logic [IDX_W-1:0]       cand;
  logic [PORT_AW-1:0]     pick_addr;
  logic [PORT_DW-1:0]     pick_wdata;
  logic [BEAT_W-1:0]      beat_nxt;

  // SDRAM beat address: client word address with the beat number as the low bits.
  function automatic logic [SDRAM_AW-1:0] beat_addr(input logic [PORT_AW-1:0] a,
                                                    input logic [BEAT_W-1:0]  b);
    logic [SDRAM_AW-1:0] r;
    r = SDRAM_AW'(a) << LOG_BEATS;
    if (LOG_BEATS > 0) begin
      r = r | SDRAM_AW'(b);
    end
    return r;
  endfunction

  // Round-robin pick: first requesting port strictly after the last one served.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = IDX_W'((int'(last_grant_q) + k) % NUM_PORTS);
      if (!pick_found && port_req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
    pick_addr  = port_addr[int'(pick_idx)*PORT_AW +: PORT_AW];
    pick_wdata = port_wdata[int'(pick_idx)*PORT_DW +: PORT_DW];
  end

  // Transaction FSM: latch a winner, issue BEATS beats, reassemble reads, report completion.
  always_comb begin
    state_d            = state_q;
    last_grant_d       = last_grant_q;
    idx_d              = idx_q;
    beat_d             = beat_q;
    addr_d             = addr_q;
    wdata_d            = wdata_q;
    grant_d            = grant_q;
    port_done_d        = '0;
    sdram_rw_d         = sdram_rw_q;
    sdram_addr_d       = sdram_addr_q;
    sdram_data_write_d = sdram_data_write_q;
    port_rdata_d       = port_rdata_q;
    beat_nxt           = beat_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        // Late sdram_done from an abandoned beat lands here and is dropped.
        if (pick_found) begin
          idx_d              = pick_idx;
          sdram_rw_d         = port_rw[pick_idx];
          addr_d             = pick_addr;
          wdata_d            = pick_wdata;
          beat_d             = '0;
          grant_d            = NUM_PORTS'(1) << pick_idx;
          sdram_addr_d       = beat_addr(pick_addr, '0);
          sdram_data_write_d = pick_wdata[SDRAM_DW-1:0];
          state_d            = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (sdram_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (sdram_done) begin
          if (sdram_rw_q) begin
            port_rdata_d[int'(beat_q)*SDRAM_DW +: SDRAM_DW] = sdram_data_read;
          end
          if (beat_q == BEAT_W'(BEATS-1)) begin
            port_done_d = grant_q;
            state_d     = S_DONE;
          end else begin
            beat_d             = beat_nxt;
            sdram_addr_d       = beat_addr(addr_q, beat_nxt);
            sdram_data_write_d = wdata_q[int'(beat_nxt)*SDRAM_DW +: SDRAM_DW];
            state_d            = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        last_grant_d = idx_q;
        grant_d      = '0;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any in-flight beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= S_IDLE;
      last_grant_q       <= IDX_W'(NUM_PORTS-1);
      idx_q              <= '0;
      beat_q             <= '0;
      addr_q             <= '0;
      wdata_q            <= '0;
      grant_q            <= '0;
      busy_q             <= 1'b0;
      port_done_q        <= '0;
      sdram_rw_q         <= 1'b0;
      sdram_addr_q       <= '0;
      sdram_data_write_q <= '0;
      port_rdata_q       <= '0;
    end else begin
      state_q            <= state_d;
      last_grant_q       <= last_grant_d;
      idx_q              <= idx_d;
      beat_q             <= beat_d;
      addr_q             <= addr_d;
      wdata_q            <= wdata_d;
      grant_q            <= grant_d;
      busy_q             <= busy_d;
      port_done_q        <= port_done_d;
      sdram_rw_q         <= sdram_rw_d;
      sdram_addr_q       <= sdram_addr_d;
      sdram_data_write_q <= sdram_data_write_d;
      port_rdata_q       <= port_rdata_d;
    end
  end

  // The strobe qualifies the registered ISSUE state with ready, so it is high
  // for exactly the one cycle in which the command is accepted.
  assign sdram_as         = (state_q == S_ISSUE) && sdram_ready;
  assign sdram_rw         = sdram_rw_q;
  assign sdram_addr       = sdram_addr_q;
  assign sdram_data_write = sdram_data_write_q;
  assign port_rdata       = port_rdata_q;
  assign port_done        = port_done_q;
  assign grant            = grant_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - scoreboard bench with SDRAM responder and word-level reference model
module tb_sdram_port_arbiter;

  localparam int NP    = 4;
  localparam int SDW   = 16;
  localparam int SAW   = 23;
  localparam int PDW   = 32;
  localparam int BEATS = PDW / SDW;
  localparam int PAW   = SAW - $clog2(BEATS);

  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0]     port_req, port_rw;
  logic [NP*PAW-1:0] port_addr;
  logic [NP*PDW-1:0] port_wdata;
  logic [PDW-1:0]    port_rdata;
  logic [NP-1:0]     port_done, grant;
  logic              busy;
  logic              sdram_ready, sdram_as, sdram_rw, sdram_done;
  logic [SAW-1:0]    sdram_addr;
  logic [SDW-1:0]    sdram_data_write, sdram_data_read;

  bit             req_a[NP];
  bit             rw_a[NP];
  logic [PAW-1:0] addr_a[NP];
  logic [PDW-1:0] wdata_a[NP];

  always_comb begin
    port_req   = '0;
    port_rw    = '0;
    port_addr  = '0;
    port_wdata = '0;
    for (int i = 0; i < NP; i++) begin
      port_req[i]                = req_a[i];
      port_rw[i]                 = rw_a[i];
      port_addr[i*PAW +: PAW]    = addr_a[i];
      port_wdata[i*PDW +: PDW]   = wdata_a[i];
    end
  end

  sdram_port_arbiter #(.NUM_PORTS(NP), .SDRAM_DW(SDW), .SDRAM_AW(SAW), .PORT_DW(PDW)) dut (
    .clk(clk), .rst(rst),
    .port_req(port_req), .port_rw(port_rw), .port_addr(port_addr), .port_wdata(port_wdata),
    .port_rdata(port_rdata), .port_done(port_done), .grant(grant), .busy(busy),
    .sdram_ready(sdram_ready), .sdram_as(sdram_as), .sdram_rw(sdram_rw),
    .sdram_addr(sdram_addr), .sdram_data_write(sdram_data_write),
    .sdram_data_read(sdram_data_read), .sdram_done(sdram_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             port;
    bit             rw;
    logic [PAW-1:0] addr;
    logic [PDW-1:0] wdata;
  } txn_t;

  txn_t           pend[$];
  logic [PDW-1:0] wmem[int];
  logic [SDW-1:0] bmem[int];
  int             grant_log[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: expected event did not happen", name);
  endtask

  function automatic logic [SDW-1:0] fill(input int a);
    logic [31:0] v;
    v = a * 40503 ^ 32'h5A5A;
    return v[SDW-1:0];
  endfunction

  function automatic logic [SDW-1:0] bread(input int a);
    return bmem.exists(a) ? bmem[a] : fill(a);
  endfunction

  // Word-level view of memory: little-endian pair of beat-level background values.
  function automatic logic [PDW-1:0] refword(input int a);
    return wmem.exists(a) ? wmem[a] : {fill(2*a+1), fill(2*a)};
  endfunction

  function automatic int rr_pick(input int last, input logic [NP-1:0] req);
    for (int k = 1; k <= NP; k++) begin
      if (req[(last + k) % NP]) return (last + k) % NP;
    end
    return -1;
  endfunction

  // SDRAM responder controls
  int  cnt = 0;
  int  pend_addr = 0;
  bit  pend_rw = 0;
  int  delay_max = 1;
  bit  rand_ready = 0;
  int  stall_cycles = 0;
  bit  force_done = 0;
  int  dup_mode = 0;

  initial begin
    sdram_ready = 1'b0;
    sdram_done = 1'b0;
    sdram_data_read = '0;
    forever begin
      @(posedge clk);
      #2;
      sdram_done = 1'b0;
      sdram_data_read = '0;
      if (rst) cnt = 0;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          sdram_done = 1'b1;
          if (pend_rw) sdram_data_read = bread(pend_addr);
        end
      end
      if (force_done) begin
        sdram_done = 1'b1;
        sdram_data_read = 16'h0BAD;
        force_done = 0;
      end
      if (stall_cycles > 0) begin
        sdram_ready = 1'b0;
        stall_cycles--;
      end else begin
        sdram_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      #1;
      if (sdram_as && !rst) begin
        pend_addr = int'(sdram_addr);
        pend_rw   = sdram_rw;
        if (!sdram_rw) bmem[int'(sdram_addr)] = sdram_data_write;
        cnt = (delay_max > 1) ? $urandom_range(1, delay_max) : 1;
        if (dup_mode == 1 || (dup_mode == 2 && $urandom_range(0, 3) == 0)) begin
          sdram_done = 1'b1;
          sdram_data_read = 16'h0BAD;
        end
      end
    end
  end

  // Monitor / scoreboard
  int             last_model = NP-1;
  logic           as_prev = 1'b0;
  logic [NP-1:0]  grant_prev = '0;
  logic [NP-1:0]  req_prev = '0;
  txn_t           cur;
  bit             cur_valid = 0;
  int             beat_idx = 0;
  int             mon_e, mon_p, mon_i;

  always @(negedge clk) begin
    if (rst) begin
      last_model = NP-1;
      as_prev    = 1'b0;
      grant_prev = '0;
      req_prev   = '0;
      cur_valid  = 0;
      beat_idx   = 0;
    end else begin
      if (grant_prev == '0 && grant != '0) begin
        mon_e = rr_pick(last_model, req_prev);
        chk("grant_rr", 64'(grant), (mon_e < 0) ? 64'd0 : (64'd1 << mon_e));
        grant_log.push_back(mon_e);
        cur_valid = 0;
        for (int i = 0; i < pend.size(); i++) begin
          if (!cur_valid && pend[i].port == mon_e) begin
            cur = pend[i];
            cur_valid = 1;
          end
        end
        beat_idx = 0;
      end
      if (sdram_as) begin
        chk("as_back_to_back", 64'(as_prev), 64'd0);
        if (cur_valid) begin
          chk("beat_addr", 64'(sdram_addr), 64'(cur.addr) * BEATS + 64'(beat_idx));
          chk("beat_rw", 64'(sdram_rw), 64'(cur.rw));
          if (!cur.rw) chk("beat_wdata", 64'(sdram_data_write), 64'(cur.wdata[beat_idx*SDW +: SDW]));
        end else begin
          fail_now("beat_owner");
        end
        beat_idx++;
      end
      if (port_done != '0) begin
        chk("done_onehot", 64'($onehot(port_done)), 64'd1);
        chk("done_vs_grant", 64'(port_done), 64'(grant));
        mon_p = -1;
        for (int i = NP-1; i >= 0; i--) if (port_done[i]) mon_p = i;
        mon_i = -1;
        for (int i = 0; i < pend.size(); i++) begin
          if (mon_i < 0 && pend[i].port == mon_p) mon_i = i;
        end
        if (mon_i < 0) begin
          fail_now("done_unexpected");
        end else begin
          if (pend[mon_i].rw) chk("rdata", 64'(port_rdata), 64'(refword(int'(pend[mon_i].addr))));
          else wmem[int'(pend[mon_i].addr)] = pend[mon_i].wdata;
          pend.delete(mon_i);
        end
        last_model = mon_p;
      end
      as_prev    = sdram_as;
      grant_prev = grant;
      req_prev   = port_req;
    end
  end

  // One client transaction; entered and left 1 time unit after a rising edge.
  task automatic client_txn(input int p, input bit rw, input logic [PAW-1:0] a,
                            input logic [PDW-1:0] wd, input bit drop_early, output int lat);
    txn_t t;
    int   n;
    bit   got;
    bit   dropped;
    t.port = p; t.rw = rw; t.addr = a; t.wdata = wd;
    pend.push_back(t);
    rw_a[p] = rw; addr_a[p] = a; wdata_a[p] = wd; req_a[p] = 1'b1;
    n = 0; got = 0; dropped = 0;
    while (!got && n < 300) begin
      @(negedge clk);
      if (port_done[p]) got = 1;
      else begin
        n++;
        if (drop_early && !dropped && grant[p]) begin
          @(posedge clk); #1;
          req_a[p] = 1'b0;
          dropped = 1;
        end
      end
    end
    lat = n;
    if (!got) fail_now($sformatf("port%0d_done_timeout", p));
    @(posedge clk); #1;
    req_a[p] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic client_run(input int p, input int n, input int max_gap, input bit rand_drop);
    int lat;
    bit rw;
    logic [PAW-1:0] a;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
      rw = $urandom_range(0, 1);
      a  = ($urandom_range(0, 3) == 0) ? PAW'($urandom) : PAW'($urandom_range(0, 15));
      client_txn(p, rw, a, $urandom, rand_drop && ($urandom_range(0, 2) == 0), lat);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdata"}, 64'(port_rdata), 64'd0);
    chk({tag, "_done"}, 64'(port_done), 64'd0);
    chk({tag, "_grant"}, 64'(grant), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_as"}, 64'(sdram_as), 64'd0);
    chk({tag, "_rw"}, 64'(sdram_rw), 64'd0);
    chk({tag, "_addr"}, 64'(sdram_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(sdram_data_write), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int lat;
  int start;
  int n;
  txn_t t;

  initial begin
    for (int i = 0; i < NP; i++) begin
      req_a[i] = 0; rw_a[i] = 0; addr_a[i] = '0; wdata_a[i] = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");

    // Port 0 requesting as reset releases wins first.
    @(posedge clk); #1;
    rst = 1'b0;
    start = grant_log.size();
    client_txn(0, 1'b0, 22'h5, 32'h11223344, 1'b0, lat);
    chk("first_grant_port0", 64'(grant_log.size() > start ? grant_log[start] : -1), 64'd0);

    // Single read, minimum latency.
    bmem[32'h2468A] = 16'hBEEF;
    bmem[32'h2468B] = 16'hCAFE;
    wmem[32'h12345] = 32'hCAFEBEEF;
    client_txn(2, 1'b1, 22'h12345, 32'h0, 1'b0, lat);
    chk("read_latency", 64'(lat), 64'd5);
    chk("read_word", 64'(port_rdata), 64'hCAFEBEEF);

    // Single write with the controller stalling.
    stall_cycles = 4;
    client_txn(1, 1'b0, 22'h10, 32'hDEADBEEF, 1'b0, lat);
    chk("write_stall_latency", 64'(lat), 64'd8);
    chk("write_beat0", 64'(bread(32'h20)), 64'hBEEF);
    chk("write_beat1", 64'(bread(32'h21)), 64'hDEAD);
    chk("rdata_held_over_write", 64'(port_rdata), 64'hCAFEBEEF);

    // Reset in WAIT of beat 0, then a stray done after release.
    t.port = 3; t.rw = 1'b1; t.addr = 22'h7; t.wdata = '0;
    pend.push_back(t);
    rw_a[3] = 1'b1; addr_a[3] = 22'h7; req_a[3] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!sdram_as && n < 20);
    if (!sdram_as) fail_now("midburst_as");
    @(posedge clk); #1;
    rst = 1'b1;
    req_a[3] = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midburst");
    @(posedge clk); #1;
    rst = 1'b0;
    pend.delete();
    force_done = 1;
    repeat (4) begin
      @(negedge clk);
      chk("stray_done_port_done", 64'(port_done), 64'd0);
      chk("stray_done_busy", 64'(busy), 64'd0);
    end
    @(posedge clk); #1;
    client_txn(3, 1'b1, 22'h7, 32'h0, 1'b0, lat);
    chk("post_reset_latency", 64'(lat), 64'd5);
    chk("post_reset_rdata", 64'(port_rdata), 64'(refword(7)));

    // Round-robin fairness with all ports requesting continuously.
    start = grant_log.size();
    fork
      client_run(0, 2, 0, 1'b0);
      client_run(1, 2, 0, 1'b0);
      client_run(2, 2, 0, 1'b0);
      client_run(3, 2, 0, 1'b0);
    join
    for (int k = 0; k < 8; k++) begin
      chk("rr_order", 64'(grant_log.size() > start + k ? grant_log[start + k] : -1), 64'(k % NP));
    end

    // Protocol edges: done coinciding with every as, req dropped mid-transaction.
    dup_mode = 1;
    client_txn(2, 1'b1, 22'h12345, 32'h0, 1'b1, lat);
    chk("dup_done_latency", 64'(lat), 64'd5);
    chk("dup_done_rdata", 64'(port_rdata), 64'hCAFEBEEF);

    // Randomised traffic against the reference model.
    dup_mode   = 2;
    rand_ready = 1;
    delay_max  = 3;
    fork
      client_run(0, 12, 3, 1'b1);
      client_run(1, 12, 3, 1'b1);
      client_run(2, 12, 3, 1'b1);
      client_run(3, 12, 3, 1'b1);
    join
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pending_empty", 64'(pend.size()), 64'd0);
    chk("idle_at_end", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
